sram_bist_ctrl: RTL
===================

Name: sram_bist_ctrl

Overview:
Built-in self-test controller that drives the BIST port (A_BIST_*) of one RM_IHPSG13_1P single-port SRAM macro. It is the initiator side of that port.
- Runs a March C- sequence over the whole array.
- Compares read data one cycle after each read.
- Reports pass/fail to chip_core.
- While idle it holds A_BIST_EN low, so the macro's functional port stays in control.

Parameters:
- ADDR_W, 10, address width; depth N = 2**ADDR_W words.
- DATA_W, 32, data width of the macro.

Ports:
- clk  input  1  clock; the same clk also feeds A_BIST_CLK at top level.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a test run; sampled only in IDLE.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result of the last completed run; valid from done onward.
- fail_addr  output  ADDR_W  address of the first failing read.
- fail_elem  output  3  March element (0..5) of the first failure.
- bist_en  output  1  to A_BIST_EN.
- bist_men  output  1  to A_BIST_MEN.
- bist_wen  output  1  to A_BIST_WEN.
- bist_ren  output  1  to A_BIST_REN.
- bist_addr  output  ADDR_W  to A_BIST_ADDR.
- bist_din  output  DATA_W  to A_BIST_DIN.
- bist_bm  output  DATA_W  to A_BIST_BM.
- bist_dout  input  DATA_W  from A_DOUT; valid the cycle after a read is issued.

Behaviour:
- Reset: reset is rst_n, synchronous, active-low; clock is clk. The reset values are:
  - all outputs 0, state IDLE;
  - pass 0;
  - any in-flight compare is discarded;
  - no done pulse is generated.
- All bist_* outputs are registered.
- bist_bm is all-ones whenever bist_en=1, and 0 otherwise.
- bist_men = bist_en.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: when start=1, load element 0 at address 0 and go to RUN. start in any other state is ignored.
  - RUN: issue one operation per cycle with bist_en=1. busy=1.
  - DRAIN: one cycle for the final compare. busy=1; bist_en, bist_wen and bist_ren are all 0.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE. A start held high re-launches from IDLE on the following cycle.
- March C- elements; backgrounds are 0 = all-zeros and 1 = all-ones:
  - E0 ascending (w0)
  - E1 ascending (r0, w1)
  - E2 ascending (r1, w0)
  - E3 descending (r0, w1)
  - E4 descending (r1, w0)
  - E5 ascending (r0)
- Within each address, the read precedes the write (two cycles). The address advances after the last operation of that address.
- Ascending elements run 0..N-1; descending elements run N-1..0. Address wrap-around ends the element; no address outside 0..N-1 is ever driven.
- Write cycle: bist_wen=1, bist_ren=0, bist_din = background.
- Read cycle: bist_ren=1, bist_wen=0, bist_din=0.
- Total operations: 10N. If start is sampled at cycle t0:
  - operations are issued at t0+1 .. t0+10N;
  - DRAIN is at t0+10N+1;
  - the done pulse is at t0+10N+2.
- Compare: the registered expected value and the valid flag follow each read by one cycle. A mismatch sets a sticky fail flag.
- The run always completes; there is no early abort.
- pass = !fail is updated in DONE and cleared at the next start.

Optional Feature:
- Macro: SRAM_BIST_DIAG_EN.
- Defined: fail_addr and fail_elem capture the address and element of the first mismatch only. Later mismatches do not overwrite them. Both clear at start.
- Undefined: fail_addr and fail_elem are tied to 0 and no capture registers are built. pass behaviour is unchanged.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, bist_en=0, pass=0.
- Clean memory model, ADDR_W=4 (N=16): start at t0 ->
  - busy high t0+1..t0+161;
  - 160 operations, first a write to address 0 with din=0;
  - done at t0+162, pass=1.
- Stuck-at-1 on bit 5 at address 3, ADDR_W=4, DIAG_EN defined -> pass=0, fail_addr=3, fail_elem=1.
- Element ordering, ADDR_W=4:
  - the first E3 operation is a read at address 15 expecting 0;
  - the E3 write at address 15 has din=all-ones;
  - the last operation overall is a read at address 15 (E5).
- start pulsed while busy -> ignored, run length still 160 operations.
- start held high -> the second run starts 1 cycle after the DONE cycle.
- rst_n=0 asserted mid-E2 -> next cycle bist_en=0, busy=0; no done pulse, pass=0.

Source files
------------

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller driving the RM_IHPSG13_1P SRAM BIST port.
// Define SRAM_BIST_DIAG_EN to capture first-failure address/element.
module sram_bist_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] bist_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] E_LAST = 3'd5;
  localparam logic [ADDR_W-1:0] A_TOP = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] A_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic has_rd(
    input logic [2:0] e
  );
    return e != 3'd0;
  endfunction

  function automatic logic has_wr(
    input logic [2:0] e
  );
    return e != E_LAST;
  endfunction

  function automatic logic is_dn(
    input logic [2:0] e
  );
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic rd_bg(
    input logic [2:0] e
  );
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic wr_bg(
    input logic [2:0] e
  );
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [ADDR_W-1:0] first_a(
    input logic [2:0] e
  );
    return is_dn(e) ? A_TOP : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] last_a(
    input logic [2:0] e
  );
    return is_dn(e) ? '0 : A_TOP;
  endfunction

  state_t state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic rd_q, rd_d;

  logic en_q, en_d;
  logic wen_q, wen_d;
  logic ren_q, ren_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic cmp_vld_q, cmp_vld_d;
  logic exp_bg_q, exp_bg_d;
  logic fail_q, fail_d;
  logic pass_q, pass_d;

  logic issue;
  logic clr;
  logic mism;

  // pointer regs always describe the op currently on the port
  always_comb begin
    state_d = state_q;
    elem_d = elem_q;
    addr_d = addr_q;
    rd_d = rd_q;
    en_d = 1'b0;
    wen_d = 1'b0;
    ren_d = 1'b0;
    oaddr_d = '0;
    din_d = '0;
    issue = 1'b0;
    clr = 1'b0;
    mism = cmp_vld_q &&
      (bist_dout != {DATA_W{exp_bg_q}});
    fail_d = fail_q | mism;
    pass_d = pass_q;
    cmp_vld_d = ren_q;
    exp_bg_d = rd_bg(elem_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d = 3'd0;
          addr_d = '0;
          rd_d = 1'b0;
          fail_d = 1'b0;
          pass_d = 1'b0;
          clr = 1'b1;
          issue = 1'b1;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (rd_q && has_wr(elem_q)) begin
          rd_d = 1'b0;
        end else if (addr_q != last_a(elem_q)) begin
          addr_d = is_dn(elem_q) ?
            addr_q - A_ONE : addr_q + A_ONE;
          rd_d = has_rd(elem_q);
        end else if (elem_q != E_LAST) begin
          elem_d = elem_q + 3'd1;
          addr_d = first_a(elem_q + 3'd1);
          rd_d = has_rd(elem_q + 3'd1);
        end else begin
          state_d = S_DRAIN;
          issue = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        pass_d = !fail_d;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      en_d = 1'b1;
      ren_d = rd_d;
      wen_d = !rd_d;
      oaddr_d = addr_d;
      din_d = rd_d ? '0 : {DATA_W{wr_bg(elem_d)}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      elem_q <= 3'd0;
      addr_q <= '0;
      rd_q <= 1'b0;
      en_q <= 1'b0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      oaddr_q <= '0;
      din_q <= '0;
      cmp_vld_q <= 1'b0;
      exp_bg_q <= 1'b0;
      fail_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      en_q <= en_d;
      wen_q <= wen_d;
      ren_q <= ren_d;
      oaddr_q <= oaddr_d;
      din_q <= din_d;
      cmp_vld_q <= cmp_vld_d;
      exp_bg_q <= exp_bg_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end

`ifdef SRAM_BIST_DIAG_EN
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [2:0] cap_elem_q, cap_elem_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [2:0] fe_q, fe_d;

  // only the first mismatch of a run is kept
  always_comb begin
    cap_addr_d = addr_q;
    cap_elem_d = elem_q;
    fa_d = fa_q;
    fe_d = fe_q;
    if (clr) begin
      fa_d = '0;
      fe_d = 3'd0;
    end else if (mism && !fail_q) begin
      fa_d = cap_addr_q;
      fe_d = cap_elem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_addr_q <= '0;
      cap_elem_q <= 3'd0;
      fa_q <= '0;
      fe_q <= 3'd0;
    end else begin
      cap_addr_q <= cap_addr_d;
      cap_elem_q <= cap_elem_d;
      fa_q <= fa_d;
      fe_q <= fe_d;
    end
  end

  assign fail_addr = fa_q;
  assign fail_elem = fe_q;
`else
  assign fail_addr = '0;
  assign fail_elem = 3'd0;
`endif

  assign busy = (state_q == S_RUN) ||
                (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign pass = pass_q;
  assign bist_en = en_q;
  assign bist_men = en_q;
  assign bist_wen = wen_q;
  assign bist_ren = ren_q;
  assign bist_addr = oaddr_q;
  assign bist_din = din_q;
  assign bist_bm = {DATA_W{en_q}};

endmodule
